// File: rtl/piano_pkg.sv
// Shared constants and helpers for the piano audio path.
// Sample width, the midscale silence code and the PWM period length live here.
package piano_pkg;

  localparam int SAMPLE_W   = 8;
  localparam int PWM_PERIOD = 256;
  localparam int CNT_W      = $clog2(PWM_PERIOD);

  localparam logic [SAMPLE_W-1:0] SILENCE = 8'h80;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]    pwm_cnt_t;

  // A period of PWM_PERIOD cycles shows exactly `duty` high cycles.
  function automatic logic pwmCompare(input pwm_cnt_t cnt, input sample_t duty);
    return (cnt < duty);
  endfunction

  function automatic logic isLastCount(input pwm_cnt_t cnt);
    return (cnt == pwm_cnt_t'(PWM_PERIOD - 1));
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small pointer-plus-count FIFO holding queued audio samples.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;

  logic w_doPush;
  logic w_doPop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_level  = r_count;
  assign o_rdata  = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap on their natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// Sample sink for the piano: queues 8-bit samples and plays each one as a
// 256-cycle PWM period on a single audio pin, flagging periods that start dry.
module pwm_audio_out
  import piano_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SAMPLE_W-1:0]    sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   pwm_out,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  pwm_cnt_t r_cnt;
  sample_t  r_duty;
  logic     r_pwm;
  logic     r_underrun;

  sample_t  w_headSample;
  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_boundary;
  logic     w_pop;

  assign sample_ready = !w_full;
  assign w_push       = sample_valid && !w_full;
  assign w_boundary   = en && isLastCount(r_cnt);
  assign w_pop        = w_boundary && !w_empty;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (sample_in),
    .o_rdata (w_headSample),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // The compare uses pre-edge cnt/duty, so a duty popped at the boundary
  // first shows up on the cycle where cnt has just wrapped to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_duty     <= SILENCE;
      r_pwm      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_cnt      <= en ? (r_cnt + pwm_cnt_t'(1)) : '0;
      r_pwm      <= en && pwmCompare(r_cnt, r_duty);
      r_underrun <= w_boundary && w_empty;
      if (w_pop) begin
        r_duty <= w_headSample;
      end
    end
  end

  assign pwm_out  = r_pwm;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: a queue-based FIFO/period model checked
// every cycle, plus per-period high-cycle counts taken from stimulus tables.
module tb_pwm_audio_out;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] sample;
    int         expHigh;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       pwm_out;
  logic       underrun;
  logic [2:0] level;

  logic [7:0] pendingPush[$];
  logic [7:0] mQ[$];
  logic [7:0] mCnt = 8'h00;
  logic [7:0] mDuty = 8'h80;
  logic       mPwm = 1'b0;
  logic       mUnder = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int highCount = 0;
  int underCount = 0;

  vec_t dutyVec[4];
  vec_t bpVec[6];

  pwm_audio_out #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .underrun     (underrun),
    .level        (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
    end
  endtask

  // One clock: drive the head of the producer queue, advance the model, compare.
  task automatic applyStimulus();
    logic boundary;
    logic accepted;
    logic ePwm;
    sample_valid = (pendingPush.size() > 0);
    sample_in    = (pendingPush.size() > 0) ? pendingPush[0] : 8'h00;
    boundary = !rst && en && (mCnt == 8'hFF);
    accepted = !rst && sample_valid && (mQ.size() < DEPTH);
    ePwm     = en && (mCnt < mDuty);
    @(posedge clk);
    #1;
    cycle++;
    if (rst) begin
      mCnt = 8'h00;
      mDuty = 8'h80;
      mQ.delete();
      mPwm = 1'b0;
      mUnder = 1'b0;
    end else begin
      mCnt = en ? mCnt + 8'd1 : 8'd0;
      mUnder = 1'b0;
      if (boundary) begin
        if (mQ.size() > 0) mDuty = mQ.pop_front();
        else mUnder = 1'b1;
      end
      if (accepted) begin
        mQ.push_back(sample_in);
        void'(pendingPush.pop_front());
      end
      mPwm = ePwm;
    end
    checkOutput("pwm_out", pwm_out, mPwm);
    checkOutput("underrun", underrun, mUnder);
    checkOutput("level", level, mQ.size());
    checkOutput("sample_ready", sample_ready, mQ.size() < DEPTH);
    if (pwm_out === 1'b1) highCount++;
    if (underrun === 1'b1) underCount++;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Runs one full period starting at cnt=0 and checks its high/underrun counts.
  task automatic runPeriod(input int expHigh, input int expUnder, input bit pushAtEnd,
                           input logic [7:0] pushVal, input string name);
    highCount = 0;
    underCount = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255 && pushAtEnd) pendingPush.push_back(pushVal);
      applyStimulus();
    end
    checkOutput({name, "_highs"}, highCount, expHigh);
    checkOutput({name, "_underruns"}, underCount, expUnder);
  endtask

  initial begin
    dutyVec[0] = '{8'h00, 0, "duty00"};
    dutyVec[1] = '{8'h01, 1, "duty01"};
    dutyVec[2] = '{8'h80, 128, "duty80"};
    dutyVec[3] = '{8'hFF, 255, "dutyFF"};
    bpVec[0] = '{8'h10, 16, "bp0"};
    bpVec[1] = '{8'h20, 32, "bp1"};
    bpVec[2] = '{8'h30, 48, "bp2"};
    bpVec[3] = '{8'h40, 64, "bp3"};
    bpVec[4] = '{8'h50, 80, "bp4"};
    bpVec[5] = '{8'h60, 96, "bp5"};

    $display("[TB] reset with sample_valid held high");
    rst = 1'b1;
    pendingPush.push_back(8'h55);
    runTicks(3);
    rst = 1'b0;
    pendingPush.delete();
    checkOutput("rst_pwm", pwm_out, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_ready", sample_ready, 1);
    checkOutput("rst_underrun", underrun, 0);

    $display("[TB] silent periods with empty FIFO");
    en = 1'b1;
    runPeriod(128, 1, 1'b0, 8'h00, "silent0");
    runPeriod(128, 1, 1'b0, 8'h00, "silent1");

    $display("[TB] duty accuracy");
    foreach (dutyVec[i]) pendingPush.push_back(dutyVec[i].sample);
    runPeriod(128, 0, 1'b0, 8'h00, "dutyLoad");
    foreach (dutyVec[i]) runPeriod(dutyVec[i].expHigh, (i == 3) ? 1 : 0, 1'b0, 8'h00, dutyVec[i].name);

    $display("[TB] backpressure");
    en = 1'b0;
    foreach (bpVec[i]) pendingPush.push_back(bpVec[i].sample);
    runTicks(6);
    checkOutput("bp_level", level, 4);
    checkOutput("bp_ready", sample_ready, 0);
    pendingPush.delete();
    runTicks(2);
    en = 1'b1;
    runPeriod(255, 0, 1'b0, 8'h00, "bpHeld");
    checkOutput("bp_ready_after_pop", sample_ready, 1);
    for (int i = 0; i < 4; i++) runPeriod(bpVec[i].expHigh, (i == 3) ? 1 : 0, 1'b0, 8'h00, bpVec[i].name);

    $display("[TB] simultaneous push and pop");
    en = 1'b0;
    pendingPush.push_back(8'h20);
    pendingPush.push_back(8'h60);
    runTicks(2);
    checkOutput("sim_prefill_level", level, 2);
    en = 1'b1;
    runPeriod(64, 0, 1'b1, 8'hA0, "simHeld");
    checkOutput("sim_level_kept", level, 2);
    runPeriod(32, 0, 1'b0, 8'h00, "simA");
    runPeriod(96, 0, 1'b0, 8'h00, "simB");
    runPeriod(160, 1, 1'b1, 8'hE0, "simC");
    checkOutput("empty_push_underrun", underrun, 1);
    checkOutput("empty_push_level", level, 1);
    runPeriod(160, 0, 1'b0, 8'h00, "simCheld");
    runPeriod(224, 1, 1'b0, 8'h00, "simD");

    $display("[TB] enable drop mid-period");
    en = 1'b0;
    pendingPush.push_back(8'hC0);
    runTicks(1);
    en = 1'b1;
    runPeriod(224, 0, 1'b0, 8'h00, "dropLoad");
    runTicks(100);
    checkOutput("drop_pwm_before", pwm_out, 1);
    en = 1'b0;
    runTicks(1);
    checkOutput("drop_pwm_after", pwm_out, 0);
    pendingPush.push_back(8'h40);
    runTicks(2);
    checkOutput("drop_level", level, 1);
    en = 1'b1;
    runPeriod(192, 0, 1'b0, 8'h00, "reenable");
    checkOutput("reenable_level", level, 0);

    $display("[TB] mid-operation reset");
    en = 1'b0;
    pendingPush.push_back(8'h11);
    pendingPush.push_back(8'h22);
    pendingPush.push_back(8'h33);
    runTicks(3);
    checkOutput("midrst_prefill", level, 3);
    en = 1'b1;
    runTicks(50);
    rst = 1'b1;
    runTicks(1);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_pwm", pwm_out, 0);
    checkOutput("midrst_ready", sample_ready, 1);
    rst = 1'b0;
    runPeriod(128, 1, 1'b0, 8'h00, "postReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
